// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP receive constants, FSM state type and header byte selectors.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        ETH_HEAD = 3'd2,
        IP_HEAD  = 3'd3,
        UDP_HEAD = 3'd4,
        RX_DATA  = 3'd5,
        RX_END   = 3'd6
    } rx_state_t;

    // Byte idx of a MAC address in wire order (idx 0 is the most significant byte).
    function automatic logic [7:0] sel_byte48(input logic [47:0] v, input logic [15:0] idx);
        logic [7:0] b;
        case (idx)
            16'd0:   b = v[47:40];
            16'd1:   b = v[39:32];
            16'd2:   b = v[31:24];
            16'd3:   b = v[23:16];
            16'd4:   b = v[15:8];
            16'd5:   b = v[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sel_byte32(input logic [31:0] v, input logic [15:0] idx);
        logic [7:0] b;
        case (idx)
            16'd0:   b = v[31:24];
            16'd1:   b = v[23:16];
            16'd2:   b = v[15:8];
            16'd3:   b = v[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_rx_packer.sv
// Packs payload bytes MSB-first into 32-bit words, zero-pads a short final word
// and generates the word strobe and packet-complete pulse.
module udp_rx_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    input  logic        i_empty_done,
    output logic        o_rec_en,
    output logic [31:0] o_rec_data,
    output logic        o_rec_pkt_done
);

    logic [1:0]  r_idx;
    logic [31:0] r_acc;
    logic        r_rec_en;
    logic [31:0] r_rec_data;
    logic        r_rec_pkt_done;
    logic [31:0] w_word;
    logic        w_emit;

    // A fresh word starts from zero so a short tail comes out left-aligned and padded.
    always_comb begin
        w_word = (r_idx == 2'd0) ? 32'h0000_0000 : r_acc;
        case (r_idx)
            2'd0:    w_word[31:24] = i_byte;
            2'd1:    w_word[23:16] = i_byte;
            2'd2:    w_word[15:8]  = i_byte;
            2'd3:    w_word[7:0]   = i_byte;
            default: w_word        = r_acc;
        endcase
        w_emit = i_byte_vld && ((r_idx == 2'd3) || i_last);
    end

    // Accumulator and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx          <= 2'd0;
            r_acc          <= 32'h0000_0000;
            r_rec_en       <= 1'b0;
            r_rec_data     <= 32'h0000_0000;
            r_rec_pkt_done <= 1'b0;
        end else begin
            r_rec_en       <= w_emit;
            r_rec_pkt_done <= (i_byte_vld && i_last) || i_empty_done;
            if (w_emit) begin
                r_rec_data <= w_word;
            end
            if (i_start) begin
                r_idx <= 2'd0;
            end else if (i_byte_vld) begin
                r_idx <= r_idx + 2'd1;
                r_acc <= w_word;
            end
        end
    end

    assign o_rec_en       = r_rec_en;
    assign o_rec_data     = r_rec_data;
    assign o_rec_pkt_done = r_rec_pkt_done;

endmodule

// File: rtl/udp_rx.sv
// GMII receive parser: checks preamble/SFD and the Ethernet, IPv4 and UDP headers
// against the board address, then streams the UDP payload into the word packer.
module udp_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_i,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num
);

    rx_state_t   r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic        r_mac_hit, r_mac_bc, r_etype_hi_ok;
    logic [5:0]  r_ip_hlen;
    logic [7:0]  r_len_hi;
    logic [15:0] r_byte_num;
    logic [15:0] w_udp_len;
    logic        w_byte_vld, w_last, w_start, w_empty_done, w_eth_ok;

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_udp_len = {r_len_hi, gmii_rxd};
    assign w_eth_ok  = (r_mac_hit || r_mac_bc) && r_etype_hi_ok && (gmii_rxd == ETYPE_IPV4[7:0]);

    // Next-state and byte-counter logic; dv falling mid-frame aborts straight to IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_byte_vld   = 1'b0;
        w_last       = 1'b0;
        w_start      = 1'b0;
        w_empty_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (gmii_rx_dv && (gmii_rxd == ETH_PREAMBLE)) begin
                    w_state_nxt = PREAMBLE;
                    w_cnt_nxt   = 16'd1;
                end else begin
                    w_cnt_nxt   = 16'd0;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt < 16'd7) begin
                    if (gmii_rxd == ETH_PREAMBLE) begin
                        w_cnt_nxt = w_cnt_inc;
                    end else begin
                        w_state_nxt = RX_END;
                    end
                end else if (gmii_rxd == ETH_SFD) begin
                    w_state_nxt = ETH_HEAD;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_state_nxt = RX_END;
                end
            end
            ETH_HEAD: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 16'd13) begin
                    w_state_nxt = w_eth_ok ? IP_HEAD : RX_END;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            IP_HEAD: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else if ((r_cnt == 16'd0) && (gmii_rxd[3:0] < 4'd5)) begin
                    w_state_nxt = RX_END;
                end else if ((r_cnt == 16'd9) && (gmii_rxd != IP_PROTO_UDP)) begin
                    w_state_nxt = RX_END;
                end else if ((r_cnt >= 16'd16) && (r_cnt <= 16'd19) &&
                             (gmii_rxd != sel_byte32(BOARD_IP, r_cnt - 16'd16))) begin
                    w_state_nxt = RX_END;
                end else if ((r_cnt != 16'd0) && (r_cnt == {10'd0, r_ip_hlen} - 16'd1)) begin
                    w_state_nxt = UDP_HEAD;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            UDP_HEAD: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else if ((r_cnt == 16'd5) && (w_udp_len < UDP_HDR_LEN)) begin
                    w_state_nxt = RX_END;
                end else if (r_cnt == 16'd7) begin
                    w_cnt_nxt = 16'd0;
                    if (r_byte_num == 16'd0) begin
                        w_empty_done = 1'b1;
                        w_state_nxt  = RX_END;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = RX_DATA;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RX_DATA: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_byte_vld = 1'b1;
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == r_byte_num) begin
                        w_last      = 1'b1;
                        w_state_nxt = RX_END;
                    end else begin
                        w_last      = 1'b0;
                    end
                end
            end
            RX_END: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RX_END;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // State and byte counter registers.
    always_ff @(posedge gmii_rx_clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Header field capture: MAC match flags, ethertype high byte, IHL and UDP length.
    always_ff @(posedge gmii_rx_clk or posedge rst_i) begin
        if (rst_i) begin
            r_mac_hit     <= 1'b0;
            r_mac_bc      <= 1'b0;
            r_etype_hi_ok <= 1'b0;
            r_ip_hlen     <= 6'd0;
            r_len_hi      <= 8'd0;
            r_byte_num    <= 16'd0;
        end else begin
            if (r_state == PREAMBLE) begin
                r_mac_hit <= 1'b1;
                r_mac_bc  <= 1'b1;
            end else if ((r_state == ETH_HEAD) && gmii_rx_dv && (r_cnt < 16'd6)) begin
                r_mac_hit <= r_mac_hit && (gmii_rxd == sel_byte48(BOARD_MAC, r_cnt));
                r_mac_bc  <= r_mac_bc && (gmii_rxd == 8'hFF);
            end
            if ((r_state == ETH_HEAD) && gmii_rx_dv && (r_cnt == 16'd12)) begin
                r_etype_hi_ok <= (gmii_rxd == ETYPE_IPV4[15:8]);
            end
            if ((r_state == IP_HEAD) && gmii_rx_dv && (r_cnt == 16'd0)) begin
                r_ip_hlen <= {gmii_rxd[3:0], 2'b00};
            end
            if ((r_state == UDP_HEAD) && gmii_rx_dv && (r_cnt == 16'd4)) begin
                r_len_hi <= gmii_rxd;
            end
            if ((r_state == UDP_HEAD) && gmii_rx_dv && (r_cnt == 16'd5) &&
                (w_udp_len >= UDP_HDR_LEN)) begin
                r_byte_num <= w_udp_len - UDP_HDR_LEN;
            end
        end
    end

    udp_rx_packer u_packer (
        .i_clk          (gmii_rx_clk),
        .i_rst          (rst_i),
        .i_start        (w_start),
        .i_byte_vld     (w_byte_vld),
        .i_byte         (gmii_rxd),
        .i_last         (w_last),
        .i_empty_done   (w_empty_done),
        .o_rec_en       (rec_en),
        .o_rec_data     (rec_data),
        .o_rec_pkt_done (rec_pkt_done)
    );

    assign rec_byte_num = r_byte_num;

endmodule

// File: tb/tb_udp_rx.sv
// Scoreboard bench for udp_rx: directed frames push hand-computed expected words,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_udp_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [7:0]  rxd;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;

    typedef struct packed {
        logic        en;
        logic [31:0] data;
        logic        done;
        logic [15:0] bnum;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] frame_q[$];
    logic [7:0] pay_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_send;

    udp_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
        .gmii_rx_clk  (clk),
        .rst_i        (rst),
        .gmii_rx_dv   (dv),
        .gmii_rxd     (rxd),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic en, input logic [31:0] data, input logic done,
                            input logic [15:0] bnum);
        exp_t e;
        e.en = en; e.data = data; e.done = done; e.bnum = bnum;
        exp_q.push_back(e);
    endtask

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                               input logic [3:0] ihl, input logic [7:0] proto,
                               input logic [31:0] dip, input logic [15:0] ulen,
                               input logic [7:0] pre3);
        frame_q.delete();
        for (int i = 0; i < 7; i++) frame_q.push_back((i == 2) ? pre3 : 8'h55);
        frame_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frame_q.push_back(dmac[i*8 +: 8]);
        frame_q.push_back(8'h02); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h01);
        frame_q.push_back(etype[15:8]); frame_q.push_back(etype[7:0]);
        frame_q.push_back({4'h4, ihl}); frame_q.push_back(8'h00);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        frame_q.push_back(8'h12); frame_q.push_back(8'h34);
        frame_q.push_back(8'h40); frame_q.push_back(8'h00);
        frame_q.push_back(8'h40); frame_q.push_back(proto);
        frame_q.push_back(8'hAB); frame_q.push_back(8'hCD);
        frame_q.push_back(8'hC0); frame_q.push_back(8'hA8);
        frame_q.push_back(8'h01); frame_q.push_back(8'h02);
        for (int i = 3; i >= 0; i--) frame_q.push_back(dip[i*8 +: 8]);
        for (int i = 0; i < (int'(ihl) - 5) * 4; i++) frame_q.push_back(8'h00);
        frame_q.push_back(8'h13); frame_q.push_back(8'h88);
        frame_q.push_back(8'h17); frame_q.push_back(8'h70);
        frame_q.push_back(ulen[15:8]); frame_q.push_back(ulen[7:0]);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
        frame_q.push_back(8'hC1); frame_q.push_back(8'hC2);
        frame_q.push_back(8'hC3); frame_q.push_back(8'hC4);
    endtask

    // Drive the first n bytes of the frame, then drop dv for a 12-byte gap.
    task automatic drive_frame(input int n);
        for (int i = 0; i < n && i < frame_q.size(); i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = frame_q[i];
        end
        @(negedge clk);
        dv  = 1'b0;
        rxd = 8'h00;
        repeat (12) @(negedge clk);
    endtask

    // Monitor: every strobe or done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rec_en || rec_pkt_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got en=%0b done=%0b data=%h, expected no output",
                         rec_en, rec_pkt_done, rec_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rec_en", {31'd0, rec_en}, {31'd0, mon_e.en});
                if (mon_e.en) check("rec_data", rec_data, mon_e.data);
                check("rec_pkt_done", {31'd0, rec_pkt_done}, {31'd0, mon_e.done});
                check("rec_byte_num", {16'd0, rec_byte_num}, {16'd0, mon_e.bnum});
            end
        end
    end

    initial begin
        rst = 1'b1;
        dv  = 1'b0;
        rxd = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_rec_en", {31'd0, rec_en}, 32'd0);
        check("reset_rec_data", rec_data, 32'd0);
        check("reset_rec_pkt_done", {31'd0, rec_pkt_done}, 32'd0);
        check("reset_rec_byte_num", {16'd0, rec_byte_num}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Eight-byte payload, two full words.
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd16, 8'h55);
        push_exp(1'b1, 32'h01020304, 1'b0, 16'd8);
        push_exp(1'b1, 32'h05060708, 1'b1, 16'd8);
        drive_frame(frame_q.size());

        // Five-byte payload, padded tail word.
        pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd13, 8'h55);
        push_exp(1'b1, 32'hAABBCCDD, 1'b0, 16'd5);
        push_exp(1'b1, 32'hEE000000, 1'b1, 16'd5);
        drive_frame(frame_q.size());

        // Rejected: wrong IP, TCP protocol, ARP ethertype, bad preamble, UDP length < 8.
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, 32'hC0A8010B, 16'd12, 8'h55);
        drive_frame(frame_q.size());
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd6, BOARD_IP, 16'd12, 8'h55);
        drive_frame(frame_q.size());
        build_frame(BOARD_MAC, 16'h0806, 4'd5, 8'd17, BOARD_IP, 16'd12, 8'h55);
        drive_frame(frame_q.size());
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd12, 8'h54);
        drive_frame(frame_q.size());
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd4, 8'h55);
        drive_frame(frame_q.size());

        // Valid frame after the rejects.
        pay_q = '{8'h11, 8'h22, 8'h33};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd11, 8'h55);
        push_exp(1'b1, 32'h11223300, 1'b1, 16'd3);
        drive_frame(frame_q.size());

        // Empty payload: done pulse without a strobe.
        pay_q.delete();
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd8, 8'h55);
        push_exp(1'b0, 32'h00000000, 1'b1, 16'd0);
        drive_frame(frame_q.size());

        // dv dropped after 6 of 12 payload bytes.
        pay_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                  8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd20, 8'h55);
        push_exp(1'b1, 32'h10111213, 1'b0, 16'd12);
        drive_frame(frame_q.size() - 4 - 6);

        // Broadcast MAC with 4 option bytes.
        pay_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        build_frame(BCAST_MAC, 16'h0800, 4'd6, 8'd17, BOARD_IP, 16'd12, 8'h55);
        push_exp(1'b1, 32'h9ABCDEF0, 1'b1, 16'd4);
        drive_frame(frame_q.size());

        // Reset pulsed after 5 of 8 payload bytes.
        pay_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd16, 8'h55);
        push_exp(1'b1, 32'h21222324, 1'b0, 16'd8);
        n_send = frame_q.size() - 4 - 3;
        for (int i = 0; i < n_send; i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = frame_q[i];
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        dv  = 1'b0;
        rxd = 8'h00;
        #1;
        check("async_rst_rec_en", {31'd0, rec_en}, 32'd0);
        check("async_rst_rec_data", rec_data, 32'd0);
        check("async_rst_rec_pkt_done", {31'd0, rec_pkt_done}, 32'd0);
        check("async_rst_rec_byte_num", {16'd0, rec_byte_num}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Full frame after reset.
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        build_frame(BOARD_MAC, 16'h0800, 4'd5, 8'd17, BOARD_IP, 16'd14, 8'h55);
        push_exp(1'b1, 32'h31323334, 1'b0, 16'd6);
        push_exp(1'b1, 32'h35360000, 1'b1, 16'd6);
        drive_frame(frame_q.size());

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_rx.md
# udp_rx

Receive-side UDP/IPv4 parser for the Ethernet path: the counterpart of the UDP transmitter driven by `udp_tx_start_en` in `u_eth_top`. It consumes the GMII receive byte stream, checks preamble/SFD, the Ethernet, IPv4 and UDP headers against the board's address, and delivers the UDP payload packed into 32-bit words with a completion pulse. It sits in `u_eth_top` beside the TX path, and `u_eth_ctrl` selects between it and the ARP path.

## Interface
- `BOARD_MAC`, 48'h00_11_22_33_44_55, accepted destination MAC; FF:FF:FF:FF:FF:FF is also accepted.
- `BOARD_IP`, 32'hC0_A8_01_0A (192.168.1.10), accepted destination IPv4 address.
- `gmii_rx_clk`  in  1  receive clock, 125 MHz; sole clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `gmii_rx_dv`  in  1  GMII receive data valid.
- `gmii_rxd`  in  8  GMII receive byte.
- `rec_en`  out  1  one-cycle strobe; `rec_data` valid.
- `rec_data`  out  32  payload word; first byte in [31:24].
- `rec_pkt_done`  out  1  one-cycle pulse: the payload of an accepted packet is complete.
- `rec_byte_num`  out  16  payload byte count of the packet (UDP length − 8). Valid from the first `rec_en` until the next packet's UDP header.

## Operation
- FSM states: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END.
- IDLE: on `gmii_rx_dv`=1 with byte 0x55, go to PREAMBLE. Count bytes from 1.
- PREAMBLE: require six more 0x55 bytes, then 0xD5. Any mismatch goes to RX_END.
- ETH_HEAD: 14 bytes.
  - Destination MAC must equal `BOARD_MAC` or be broadcast.
  - Ethertype must be 0x0800.
  - Either failure goes to RX_END at the ethertype's second byte.
- IP_HEAD:
  - IHL is taken from the low nibble of byte 0; the header length is IHL×4 bytes.
  - Byte 9 (protocol) must be 17. Bytes 16–19 must equal `BOARD_IP`.
  - On the final header byte, go to UDP_HEAD. IP options are skipped.
  - IHL<5 goes to RX_END.
- UDP_HEAD: 8 bytes. Bytes 4–5 hold the UDP length. `rec_byte_num` ← length − 8.
  - Length < 8 goes to RX_END.
  - Length = 8 (empty payload): pulse `rec_pkt_done` with no `rec_en`, then go to RX_END.
- RX_DATA:
  - Shift bytes into `rec_data`, MSB first. Assert `rec_en` on every 4th byte.
  - On the last payload byte (count = `rec_byte_num`), assert `rec_en` and `rec_pkt_done` together.
  - A partial final word is left-aligned with zero padding (e.g. 5 bytes → second word 0xEE000000).
  - Then go to RX_END.
- RX_END: ignore the remaining bytes (Ethernet padding, FCS). Go to IDLE when `gmii_rx_dv`=0.
- Checksums are not checked: neither the IP header checksum, the UDP checksum nor the FCS.
- `gmii_rx_dv` falling in any state other than IDLE or RX_END:
  - abort, return to IDLE next cycle;
  - no `rec_pkt_done`;
  - words already strobed stand.
- Byte counters are 16 bits and saturate rather than wrap.
- `rst_i` at any point, including mid-packet, gives state IDLE, counters 0 and all outputs 0. The next packet must begin with a fresh preamble.

## Timing
- Reset values: `rec_en`=0, `rec_pkt_done`=0, `rec_data`=0, `rec_byte_num`=0.
- All outputs are registered.
- `rec_en`/`rec_data` appear one cycle after the byte completing the word is sampled.
- `rec_pkt_done` is coincident with the final `rec_en`.
- `gmii_rx_dv` low at the earliest possible cycle after `rec_pkt_done` returns the FSM to IDLE. A back-to-back packet after the minimum 12-byte IFG is received.
- `rec_data` holds its value between strobes.

## Structure
- Shared package `eth_pkg`:
  - constants `ETH_PREAMBLE`=8'h55, `ETH_SFD`=8'hD5, `ETYPE_IPV4`=16'h0800, `IP_PROTO_UDP`=8'd17, `UDP_HDR_LEN`=8;
  - `rx_state_t` enum.
- One sub-module: `udp_rx_packer`, which does byte-to-32-bit packing, tail padding and the `rec_en`/`rec_pkt_done` generation.
- The header checks and FSM stay in `udp_rx`.

## Test plan
- Valid frame, destination `BOARD_MAC`/`BOARD_IP`, UDP length 16, payload 01..08 → `rec_byte_num`=8; `rec_en` ×2 with 0x01020304 and 0x05060708; `rec_pkt_done` coincident with the second strobe.
- Payload of 5 bytes AA BB CC DD EE → words 0xAABBCCDD and 0xEE000000; done on the second strobe.
- Wrong destination IP 192.168.1.11, or protocol 6, or ethertype 0x0806 → no `rec_en`, no `rec_pkt_done`; the next valid frame is received normally.
- Preamble byte 3 = 0x54 → the frame is ignored; the FSM returns to IDLE after dv falls.
- `gmii_rx_dv` dropped after 6 of 12 payload bytes → one `rec_en` (first word), no `rec_pkt_done`; the following frame is accepted.
- `rst_i` pulsed mid-payload → outputs 0 immediately (async); the next full frame is received correctly. Also: broadcast MAC with IHL=6 (4 option bytes) → payload extracted correctly.
